// File: rtl/core_myinput.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : core_myinput
// Brief  : Avalon-MM input PIO: synchronizer, optional per-bit debounce,
//          sticky edge capture and masked level interrupt.
// Rev    : 1.0 - initial release
// ============================================================================
module core_myinput #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_db;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_ec;
    logic             r_irq;

    logic [WIDTH-1:0] w_sync_out;
    logic [WIDTH-1:0] w_db_next;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_mask_next;
    logic [WIDTH-1:0] w_ec_next;
    logic             w_wr;
    logic             w_unused;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
        end else begin
            r_sync[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    assign w_sync_out = r_sync[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign w_db_next = w_sync_out;
        end else begin : g_debounce
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            for (genvar b = 0; b < WIDTH; b++) begin : g_bit
                logic [CW-1:0] r_cnt;
                logic          w_diff;
                logic          w_done;

                // Counter reaches DEBOUNCE_CYCLES only while the bit keeps differing,
                // so it saturates there and is cleared on acceptance.
                assign w_diff        = w_sync_out[b] != r_db[b];
                assign w_done        = w_diff && (r_cnt == CW'(DEBOUNCE_CYCLES));
                assign w_db_next[b]  = w_done ? w_sync_out[b] : r_db[b];

                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        r_cnt <= '0;
                    end else if (!w_diff || w_done) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end
        end
    endgenerate

    assign w_rise = ~r_db & w_db_next;
    assign w_fall = r_db & ~w_db_next;
    assign w_edge = (EDGE_TYPE == 0) ? w_rise :
                    (EDGE_TYPE == 1) ? w_fall : (w_rise | w_fall);

    assign w_wr        = chipselect & ~write_n;
    assign w_mask_next = (w_wr && address == 2'd2) ? writedata[WIDTH-1:0] : r_mask;
    assign w_clr       = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    // A new edge outranks a simultaneous write-1-to-clear.
    assign w_ec_next   = (r_ec & ~w_clr) | w_edge;
    assign w_unused    = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_db   <= '0;
            r_mask <= '0;
            r_ec   <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_db   <= w_db_next;
            r_mask <= w_mask_next;
            r_ec   <= w_ec_next;
            r_irq  <= |(w_ec_next & w_mask_next);
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata[WIDTH-1:0] = r_db;
            2'd2:    readdata[WIDTH-1:0] = r_mask;
            2'd3:    readdata[WIDTH-1:0] = r_ec;
            default: readdata = '0;
        endcase
    end

    assign irq = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_core_myinput.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_core_myinput
// Brief  : Checks three core_myinput variants (debounce/edge-type mixes)
//          against a window-based behavioural model, every cycle.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_core_myinput;

    localparam int NI         = 3;
    localparam int SS         = 2;
    localparam int DV [NI]    = '{0, 4, 2};
    localparam int EV [NI]    = '{0, 1, 2};

    logic        clk        = 1'b0;
    logic        reset_n    = 1'b0;
    logic [1:0]  address    = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n    = 1'b1;
    logic [31:0] writedata  = 32'h0;
    logic [7:0]  in_port    = 8'h00;
    logic [31:0] rd   [NI];
    logic        irqv [NI];

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            core_myinput #(
                .WIDTH(8), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DV[g]), .EDGE_TYPE(EV[g])
            ) u_dut (
                .clk(clk), .reset_n(reset_n), .address(address),
                .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
                .in_port(in_port), .readdata(rd[g]), .irq(irqv[g])
            );
        end
    endgenerate

    // Model: hist[j] is the pin value sampled j edges ago.
    logic [7:0] hist   [16];
    logic [7:0] m_db   [NI];
    logic [7:0] m_mask [NI];
    logic [7:0] m_ec   [NI];
    logic       m_irq  [NI];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic model_reset();
        for (int j = 0; j < 16; j++) hist[j] = 8'h00;
        for (int i = 0; i < NI; i++) begin
            m_db[i] = 8'h00; m_mask[i] = 8'h00; m_ec[i] = 8'h00; m_irq[i] = 1'b0;
        end
    endtask

    // A bit of db flips when the last D+1 synchronized samples all disagree with it.
    task automatic model_edge();
        logic [7:0] nd, rise, fall, setv, clr;
        logic       ok;
        for (int j = 15; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = in_port;
        for (int i = 0; i < NI; i++) begin
            nd = m_db[i];
            for (int b = 0; b < 8; b++) begin
                ok = 1'b1;
                for (int j = SS; j <= SS + DV[i]; j++)
                    if (hist[j][b] == m_db[i][b]) ok = 1'b0;
                if (ok) nd[b] = ~m_db[i][b];
            end
            rise = ~m_db[i] & nd;
            fall = m_db[i] & ~nd;
            case (EV[i])
                0:       setv = rise;
                1:       setv = fall;
                default: setv = rise | fall;
            endcase
            clr = 8'h00;
            if (chipselect && !write_n && address == 2'd2) m_mask[i] = writedata[7:0];
            if (chipselect && !write_n && address == 2'd3) clr = writedata[7:0];
            m_ec[i]  = (m_ec[i] & ~clr) | setv;
            m_irq[i] = |(m_ec[i] & m_mask[i]);
            m_db[i]  = nd;
        end
    endtask

    function automatic logic [31:0] exp_rd(input int i);
        case (address)
            2'd0:    return {24'h0, m_db[i]};
            2'd2:    return {24'h0, m_mask[i]};
            2'd3:    return {24'h0, m_ec[i]};
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d @%0t: got %h expected %h", nm, inst, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < NI; i++) begin
            chk("readdata", i, rd[i], exp_rd(i));
            chk("irq", i, {31'b0, irqv[i]}, {31'b0, m_irq[i]});
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset_n) model_reset();
        else model_edge();
        #1;
        compare_all();
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        step();
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
    endtask

    task automatic lit(input string nm, input logic [1:0] a, input int inst, input logic [31:0] exp);
        address = a;
        #1;
        chk(nm, inst, rd[inst], exp);
    endtask

    task automatic lit_irq(input string nm, input int inst, input logic exp);
        chk(nm, inst, {31'b0, irqv[inst]}, {31'b0, exp});
    endtask

    task automatic reset_now();
        reset_n = 1'b0;
        model_reset();
        #1;
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            #0.5;
            for (int i = 0; i < NI; i++) chk("rst_reg", i, rd[i], 32'h0);
        end
        for (int i = 0; i < NI; i++) lit_irq("rst_irq", i, 1'b0);
    endtask

    initial begin
        int r, idx;
        model_reset();
        steps(3);
        reset_n = 1'b1;
        steps(3);
        for (int i = 0; i < NI; i++) lit("reset_ec", 2'd3, i, 32'h0);

        // Basic sampling latency and rising capture
        in_port = 8'h05;
        steps(2);
        lit("data_early", 2'd0, 0, 32'h0);
        step();
        lit("data_k2", 2'd0, 0, 32'h5);
        lit("ec_rise", 2'd3, 0, 32'h5);
        lit_irq("irq_masked", 0, 1'b0);
        lit("data_db4", 2'd0, 1, 32'h0);
        steps(8);
        lit("data_db4_late", 2'd0, 1, 32'h5);
        lit("ec_fall_only", 2'd3, 1, 32'h0);
        lit("ec_any", 2'd3, 2, 32'h5);

        // Masked interrupt and write-1-to-clear
        wr(2'd3, 32'hFF);
        wr(2'd2, 32'hFF);
        in_port = 8'h85;
        steps(2);
        lit("ec7_pre", 2'd3, 0, 32'h0);
        lit_irq("irq_pre", 0, 1'b0);
        step();
        lit("ec7_set", 2'd3, 0, 32'h80);
        lit_irq("irq_set", 0, 1'b1);
        wr(2'd3, 32'h80);
        lit("ec7_clr", 2'd3, 0, 32'h0);
        lit_irq("irq_clr", 0, 1'b0);

        // Glitch rejection and debounce latency on the D=4 variant
        in_port = 8'h84;
        steps(10);
        wr(2'd3, 32'hFF);
        in_port = 8'h85;
        steps(3);
        in_port = 8'h84;
        steps(10);
        lit("glitch_data", 2'd0, 1, 32'h84);
        lit("glitch_ec", 2'd3, 1, 32'h0);
        in_port = 8'h85;
        steps(6);
        lit("pulse_pre", 2'd0, 1, 32'h84);
        in_port = 8'h84;
        step();
        lit("pulse_db", 2'd0, 1, 32'h85);
        steps(12);
        lit("pulse_back", 2'd0, 1, 32'h84);

        // Capture set coincides with write-1-to-clear of the same bit
        in_port = 8'h80;
        steps(10);
        wr(2'd3, 32'hFF);
        in_port = 8'h84;
        steps(2);
        wr(2'd3, 32'h04);
        lit("set_wins", 2'd3, 0, 32'h04);

        // Falling and any-edge capture
        steps(10);
        wr(2'd3, 32'hFF);
        in_port = 8'h86;
        steps(10);
        lit("fall_on_rise", 2'd3, 1, 32'h0);
        lit("any_on_rise", 2'd3, 2, 32'h2);
        in_port = 8'h84;
        steps(10);
        lit("fall_on_fall", 2'd3, 1, 32'h2);
        lit("any_on_fall", 2'd3, 2, 32'h2);

        // Pins high through reset, then reset mid-debounce with irq pending
        reset_now();
        in_port = 8'hFF;
        steps(3);
        reset_n = 1'b1;
        steps(8);
        lit("hi_thru_rst0", 2'd3, 0, 32'hFF);
        lit("hi_thru_rst1", 2'd3, 1, 32'h0);
        lit("hi_thru_rst2", 2'd3, 2, 32'hFF);
        wr(2'd2, 32'hFF);
        lit_irq("irq_pending", 0, 1'b1);
        in_port = 8'h00;
        steps(3);
        reset_now();
        steps(2);
        reset_n = 1'b1;
        steps(2);

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            r = int'($urandom_range(0, 15));
            if (r == 0) begin
                in_port = 8'($urandom);
            end else if (r < 5) begin
                idx = int'($urandom_range(0, 7));
                in_port[idx] = ~in_port[idx];
            end
            address    = 2'($urandom_range(0, 3));
            chipselect = 1'($urandom_range(0, 1));
            write_n    = ($urandom_range(0, 3) != 0);
            writedata  = $urandom;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
